gcd_arbiter: RTL and testbench

- Shares one 4-phase gcd core among NUM_CLIENTS requesters using round-robin arbitration.
- Accepts parallel operand pairs (A, B) from clients.
- Serialises each pair onto the core's single AB bus under the req/ack protocol.
- Returns the result tagged with the client index on a valid/ready response port.

---
 rtl/gcd_arbiter_if.sv | 47 ++++
 rtl/gcd_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gcd_arbiter_if                                            |
// | Purpose  : Bundles the client request bus, the tagged response port  |
// |            and the 4-phase core link used by gcd_arbiter.            |
// | Modports : slave  - arbiter view (drives cl_ready, rsp_*, busy,      |
// |                     core_req, core_ab)                               |
// |            master - environment view (clients, response consumer,    |
// |                     and the shared gcd core)                         |
// | Signals  : cl_valid/cl_ready   per-client request handshake          |
// |            cl_a/cl_b           packed operands, client i at [i*W+:W] |
// |            rsp_valid/rsp_ready response handshake, rsp_id/rsp_c data |
// |            busy                arbiter not idle                      |
// |            core_req/core_ab    request and operand bus to the core   |
// |            core_ack/core_c     acknowledge and result from the core  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface gcd_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int W           = 16,
  parameter int IDW         = 2
);
  logic [NUM_CLIENTS-1:0]   cl_valid;
  logic [NUM_CLIENTS-1:0]   cl_ready;
  logic [NUM_CLIENTS*W-1:0] cl_a;
  logic [NUM_CLIENTS*W-1:0] cl_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [W-1:0]             rsp_c;
  logic                     busy;
  logic                     core_req;
  logic [W-1:0]             core_ab;
  logic                     core_ack;
  logic [W-1:0]             core_c;

  modport slave (
    input  cl_valid, cl_a, cl_b, rsp_ready, core_ack, core_c,
    output cl_ready, rsp_valid, rsp_id, rsp_c, busy, core_req, core_ab
  );

  modport master (
    output cl_valid, cl_a, cl_b, rsp_ready, core_ack, core_c,
    input  cl_ready, rsp_valid, rsp_id, rsp_c, busy, core_req, core_ab
  );
endinterface
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gcd_arbiter                                               |
// | Purpose  : Round-robin front end that shares one 4-phase gcd core    |
// |            among NUM_CLIENTS requesters. A granted (A, B) pair is    |
// |            serialised onto the core's AB bus (A first, then B), and  |
// |            the result is returned tagged with the client index.      |
// | Ports    : clk    - clock                                            |
// |            reset  - asynchronous reset, active-high                  |
// |            bus    - gcd_arbiter_if.slave (client requests, tagged    |
// |                     response, core req/ack link, busy)               |
// | Params   : NUM_CLIENTS (2..8), W operand width, IDW = clog2(clients) |
// | Options  : GCD_ARB_ZERO_BYPASS_EN - when defined, a request with a   |
// |            zero operand skips the core and answers A|B directly.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module gcd_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int W           = 16,
  parameter int IDW         = 2
) (
  input  logic                clk,
  input  logic                reset,
  gcd_arbiter_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    DROP_A = 3'd2,
    SEND_B = 3'd3,
    DROP_C = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Pointer starts on the last client so client 0 wins the first arbitration.
  localparam logic [IDW-1:0] C_LAST_INIT = IDW'(NUM_CLIENTS - 1);

  state_t                  r_state;
  logic [IDW-1:0]          r_last;
  logic [IDW-1:0]          r_id;
  logic [W-1:0]            r_b;
  logic [NUM_CLIENTS-1:0]  r_cl_ready;
  logic                    r_rsp_valid;
  logic [W-1:0]            r_rsp_c;
  logic                    r_busy;
  logic                    r_core_req;
  logic [W-1:0]            r_core_ab;

  logic [W-1:0]            w_a [NUM_CLIENTS];
  logic [W-1:0]            w_b [NUM_CLIENTS];
  logic                    w_hi_any;
  logic [IDW-1:0]          w_hi_idx;
  logic                    w_lo_any;
  logic [IDW-1:0]          w_lo_idx;
  logic                    w_grant_any;
  logic [IDW-1:0]          w_grant_idx;
  logic [W-1:0]            w_grant_a;
  logic [W-1:0]            w_grant_b;
  logic                    w_bypass;

  // Unpack the flat operand buses into per-client words.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign w_a[gi] = bus.cl_a[gi*W +: W];
      assign w_b[gi] = bus.cl_b[gi*W +: W];
    end
  endgenerate

  // Round-robin search split in two halves: the lowest requester above the
  // pointer wins; if there is none, the search wraps to the lowest requester
  // overall (which is then at or below the pointer). Loops run downwards so
  // the last write, i.e. the lowest index, takes effect.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (bus.cl_valid[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = IDW'(i);
        if (i > int'(r_last)) begin
          w_hi_any = 1'b1;
          w_hi_idx = IDW'(i);
        end
      end
    end
  end

  assign w_grant_any = w_lo_any;
  assign w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_grant_a   = w_a[w_grant_idx];
  assign w_grant_b   = w_b[w_grant_idx];

`ifdef GCD_ARB_ZERO_BYPASS_EN
  // gcd(0, x) = x and gcd(0, 0) = 0, so a zero operand is answered locally;
  // the core would never terminate on it.
  assign w_bypass = (w_grant_a == '0) || (w_grant_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Controller: every output is a register updated here, so the core link
  // never sees combinational paths from core_ack back to core_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= C_LAST_INIT;
      r_id        <= '0;
      r_b         <= '0;
      r_cl_ready  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_c     <= '0;
      r_busy      <= 1'b0;
      r_core_req  <= 1'b0;
      r_core_ab   <= '0;
    end else begin
      // Accept strobe is a single-cycle pulse.
      r_cl_ready <= '0;

      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_cl_ready <= NUM_CLIENTS'(1) << w_grant_idx;
            r_id       <= w_grant_idx;
            r_last     <= w_grant_idx;
            r_b        <= w_grant_b;
            r_busy     <= 1'b1;
            if (w_bypass) begin
              r_rsp_c     <= w_grant_a | w_grant_b;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_core_req <= 1'b1;
              r_core_ab  <= w_grant_a;
              r_state    <= SEND_A;
            end
          end
        end

        SEND_A: begin
          if (bus.core_ack) begin
            r_core_req <= 1'b0;
            r_state    <= DROP_A;
          end
        end

        // req only rises again once ack has been seen low, which keeps the
        // 4-phase return-to-zero intact.
        DROP_A: begin
          if (!bus.core_ack) begin
            r_core_req <= 1'b1;
            r_core_ab  <= r_b;
            r_state    <= SEND_B;
          end
        end

        // The second ack marks completion; core_c is valid on that cycle.
        SEND_B: begin
          if (bus.core_ack) begin
            r_rsp_c    <= bus.core_c;
            r_core_req <= 1'b0;
            r_state    <= DROP_C;
          end
        end

        DROP_C: begin
          if (!bus.core_ack) begin
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_core_req  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cl_ready  = r_cl_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.busy      = r_busy;
  assign bus.core_req  = r_core_req;
  assign bus.core_ab   = r_core_ab;

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_gcd_arbiter                                            |
// | Purpose  : Self-checking bench for gcd_arbiter with a behavioural    |
// |            4-phase gcd core, a round-robin reference model and a     |
// |            response scoreboard. Honours GCD_ARB_ZERO_BYPASS_EN.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_gcd_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.NUM_CLIENTS(N), .W(W), .IDW(IDW)) bus ();

  gcd_arbiter #(.NUM_CLIENTS(N), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, t;
    a = x;
    b = y;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // First requester after 'last' in circular order, -1 when none.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = v >> ((last + k) % N);
      if (s[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = v >> k;
      if (s[0]) return k;
    end
    return -1;
  endfunction

  // ---------------- client-side drive ----------------
  logic [N-1:0] cl_valid_q = '0;
  logic [W-1:0] a_q [N];
  logic [W-1:0] b_q [N];
  logic [W-1:0] iss_a [N];
  logic [W-1:0] iss_b [N];
  int           issue_seq [N];
  int           raised_seq [N];

  assign bus.cl_valid = cl_valid_q;
  generate
    for (genvar g = 0; g < N; g++) begin : g_pack
      assign bus.cl_a[g*W +: W] = a_q[g];
      assign bus.cl_b[g*W +: W] = b_q[g];
    end
  endgenerate

  int   rr_mode = 2;   // 0 random, 1 hold low, 2 hold high
  logic rsp_ready_q = 1'b1;
  assign bus.rsp_ready = rsp_ready_q;
  always @(posedge clk) begin
    #1;
    if (rr_mode == 0) rsp_ready_q = ($urandom_range(0, 3) != 0);
    else              rsp_ready_q = (rr_mode == 2);
  end

  // ---------------- behavioural 4-phase gcd core ----------------
  int           cst = 0;
  int           cdly = 0;
  int           hs_cnt = 0;
  logic         core_slow = 1'b0;
  logic         core_ack_q;
  logic [W-1:0] core_c_q;
  logic [W-1:0] cap_a, cap_b;
  assign bus.core_ack = core_ack_q;
  assign bus.core_c   = core_c_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cst        <= 0;
      cdly       <= 0;
      core_ack_q <= 1'b0;
      core_c_q   <= '0;
    end else begin
      case (cst)
        0: if (bus.core_req) begin
             if (cdly == 0) begin
               cap_a      <= bus.core_ab;
               core_ack_q <= 1'b1;
               hs_cnt     <= hs_cnt + 1;
               cst        <= 1;
             end else cdly <= cdly - 1;
           end
        1: if (!bus.core_req) begin
             core_ack_q <= 1'b0;
             cdly       <= core_slow ? 12 : int'($urandom_range(0, 3));
             cst        <= 2;
           end
        2: if (bus.core_req) begin
             if (cdly == 0) begin
               cap_b      <= bus.core_ab;
               core_c_q   <= gcd_ref(cap_a, bus.core_ab);
               core_ack_q <= 1'b1;
               hs_cnt     <= hs_cnt + 1;
               cst        <= 3;
             end else cdly <= cdly - 1;
           end
        default: if (!bus.core_req) begin
             core_ack_q <= 1'b0;
             cdly       <= int'($urandom_range(0, 2));
             cst        <= 0;
           end
      endcase
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } exp_t;
  exp_t sbq[$];

  int nchk = 0;
  int npass = 0;
  int rsp_cnt = 0;
  int rise_cnt = 0;
  int hs_snap = 0;
  int rise_snap = 0;
  int m_last = N - 1;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  logic [N-1:0]   prev_valid = '0;
  logic [N-1:0]   prev_cl_ready = '0;
  logic           prev_rsp_valid = 1'b0;
  logic           prev_rsp_ready = 1'b0;
  logic           prev_req = 1'b0;
  logic           prev_ack = 1'b0;
  logic           in_reset = 1'b0;
  logic [IDW-1:0] held_id;
  logic [W-1:0]   held_c;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    int   g;
    int   e_idx;
    exp_t e;
    if (reset) begin
      if (!in_reset)
        chk("reset_outputs",
            {23'd0, bus.cl_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_c,
             bus.busy, bus.core_req, bus.core_ab}, 64'd0);
      in_reset = 1'b1;
      sbq.delete();
      cl_valid_q = '0;
      for (int i = 0; i < N; i++) raised_seq[i] = issue_seq[i];
      m_last = N - 1;
      hs_snap = hs_cnt;
      rise_snap = rise_cnt;
      prev_valid = '0;
      prev_cl_ready = '0;
      prev_rsp_valid = 1'b0;
      prev_rsp_ready = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      in_reset = 1'b0;

      if (bus.core_req && !prev_req) begin
        rise_cnt++;
        chk("req_rise_while_ack", {63'd0, prev_ack}, 64'd0);
      end
      if (bus.core_req || bus.rsp_valid)
        chk("busy_when_active", {63'd0, bus.busy}, 64'd1);
      if (prev_rsp_valid && prev_rsp_ready)
        chk("busy_after_resp", {63'd0, bus.busy}, 64'd0);

      if (bus.cl_ready != '0) begin
        e_idx = rr_pick(prev_valid, m_last);
        chk("cl_ready_onehot", 64'($countones(bus.cl_ready)), 64'd1);
        chk("cl_ready_one_cycle", {60'd0, prev_cl_ready}, 64'd0);
        chk("grant_index", 64'(onehot_idx(bus.cl_ready)), 64'(e_idx));
        g = (e_idx >= 0) ? e_idx : onehot_idx(bus.cl_ready);
        if (g >= 0) begin
          e.id = g;
          e.a  = a_q[g];
          e.b  = b_q[g];
          e.c  = gcd_ref(a_q[g], b_q[g]);
          sbq.push_back(e);
          m_last = g;
          cl_valid_q[g] = 1'b0;
        end
      end

      if (bus.rsp_valid) begin
        if (prev_rsp_valid && !prev_rsp_ready) begin
          chk("rsp_id_stable", 64'(bus.rsp_id), 64'(held_id));
          chk("rsp_c_stable", 64'(bus.rsp_c), 64'(held_c));
          chk("no_req_in_resp", {63'd0, bus.core_req}, 64'd0);
          chk("no_accept_in_resp", {60'd0, bus.cl_ready}, 64'd0);
        end else if (sbq.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_c", 64'(bus.rsp_c), 64'(e.c));
`ifdef GCD_ARB_ZERO_BYPASS_EN
          if (e.a == '0 || e.b == '0) begin
            chk("bypass_handshakes", 64'(hs_cnt - hs_snap), 64'd0);
            chk("bypass_req_rises", 64'(rise_cnt - rise_snap), 64'd0);
          end else begin
`else
          begin
`endif
            chk("core_handshakes", 64'(hs_cnt - hs_snap), 64'd2);
            chk("core_req_rises", 64'(rise_cnt - rise_snap), 64'd2);
            chk("core_ab_first", 64'(cap_a), 64'(e.a));
            chk("core_ab_second", 64'(cap_b), 64'(e.b));
          end
          hs_snap = hs_cnt;
          rise_snap = rise_cnt;
          rsp_cnt++;
        end
        held_id = bus.rsp_id;
        held_c  = bus.rsp_c;
      end

      for (int i = 0; i < N; i++) begin
        if (!cl_valid_q[i] && raised_seq[i] != issue_seq[i]) begin
          cl_valid_q[i] = 1'b1;
          a_q[i] = iss_a[i];
          b_q[i] = iss_b[i];
          raised_seq[i]++;
        end
      end

      if (end_req && !end_ack) begin
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        end_ack = 1'b1;
      end

      prev_valid     = cl_valid_q;
      prev_cl_ready  = bus.cl_ready;
      prev_rsp_valid = bus.rsp_valid;
      prev_rsp_ready = bus.rsp_ready;
      prev_req       = bus.core_req;
      prev_ack       = bus.core_ack;
    end
  end

  // ---------------- stimulus ----------------
  task automatic timeout(input string nm);
    $display("FAIL timeout_%s: no progress within cycle budget", nm);
    $fatal(1, "timeout");
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!(raised_seq[i] == issue_seq[i] && !cl_valid_q[i])) begin
      @(posedge clk);
      if (++n > 3000) timeout("issue");
    end
    iss_a[i] = a;
    iss_b[i] = b;
    issue_seq[i]++;
  endtask

  task automatic wait_drain();
    int  n = 0;
    bit  pend;
    do begin
      @(posedge clk);
      pend = (cl_valid_q != '0) || (sbq.size() != 0) || bus.busy;
      for (int i = 0; i < N; i++) if (raised_seq[i] != issue_seq[i]) pend = 1'b1;
      if (++n > 5000) timeout("drain");
    end while (pend);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n;
    int f;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < N; i++) begin
      issue_seq[i] = 0;
      raised_seq[i] = 0;
      a_q[i] = '0;
      b_q[i] = '0;
      iss_a[i] = '0;
      iss_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single request
    issue(0, 16'd48, 16'd18);
    wait_drain();

    // three simultaneous requests, then 0 and 3 together after serving 2
    issue(0, 16'd48, 16'd18);
    issue(1, 16'd35, 16'd14);
    issue(2, 16'd21, 16'd21);
    wait_drain();
    issue(0, 16'd12, 16'd8);
    issue(3, 16'd99, 16'd33);
    wait_drain();

    // response back-pressure
    rr_mode = 1;
    issue(0, 16'd48, 16'd18);
    n = 0;
    while (!bus.rsp_valid) begin
      @(posedge clk);
      if (++n > 1000) timeout("rsp_valid");
    end
    repeat (10) @(posedge clk);
    rr_mode = 2;
    wait_drain();

    // reset while the second operand is being presented
    core_slow = 1'b1;
    issue(1, 16'd48, 16'd18);
    n = 0;
    while (!(cst == 2 && bus.core_req)) begin
      @(posedge clk);
      if (++n > 1000) timeout("send_b");
    end
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    core_slow = 1'b0;
    repeat (5) @(posedge clk);
    issue(0, 16'd100, 16'd75);
    wait_drain();

    // randomized traffic
    rr_mode = 0;
    repeat (60) begin
      f  = $urandom_range(1, 30);
      ra = W'(f * $urandom_range(1, 200));
      rb = W'(f * $urandom_range(1, 200));
`ifdef GCD_ARB_ZERO_BYPASS_EN
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '0;
`endif
      issue($urandom_range(0, N - 1), ra, rb);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    wait_drain();

`ifdef GCD_ARB_ZERO_BYPASS_EN
    rr_mode = 2;
    issue(1, 16'd0, 16'd35);
    wait_drain();
    issue(2, 16'd0, 16'd0);
    wait_drain();
`endif

    end_req = 1'b1;
    n = 0;
    while (!end_ack) begin
      @(posedge clk);
      if (++n > 100) timeout("end");
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
